// File: rtl/drbg_keystream_serializer_if.sv
// Keystream valid/ready port between the DRBG serializer (master) and the scrambler datapath (slave).
interface drbg_keystream_serializer_if #(
  parameter int unsigned OUT_WIDTH = 8
);
  logic [OUT_WIDTH-1:0] ks_data;
  logic                 ks_valid;
  logic                 ks_ready;

  modport master (output ks_data, output ks_valid, input ks_ready);
  modport slave  (input ks_data, input ks_valid, output ks_ready);
endinterface

// File: rtl/drbg_keystream_serializer.sv
// Fetches 256-bit DRBG words into a prefetch/active double buffer and serializes them MSB-first.
// Optional feature macro: KS_UNDERRUN_CNT_EN adds the saturating ks_underruns counter port.
module drbg_keystream_serializer #(
  parameter int unsigned OUT_WIDTH     = 8,
  parameter int unsigned RESEED_BLOCKS = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] drbg_random_bits,
  input  logic         drbg_next_ready,
  input  logic         drbg_init_ready,
  input  logic         drbg_busy,
  output logic         drbg_next,
  output logic         drbg_reseed,
  input  logic         flush,
  drbg_keystream_serializer_if.master ks
`ifdef KS_UNDERRUN_CNT_EN
  ,
  output logic [15:0]  ks_underruns
`endif
);

  localparam int unsigned CHUNKS = 256 / OUT_WIDTH;
  localparam int unsigned CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {F_IDLE, F_START, F_DONE} fetch_state_e;

  fetch_state_e  state_q, state_d;
  logic          is_reseed_q, is_reseed_d;
  logic          next_d, reseed_d;
  logic          drop_q;
  logic          capture, blk_inc, blk_clr;
  logic [16:0]   blk_cnt;
  logic [255:0]  pf, active;
  logic          pf_full, ks_valid_q;
  logic [CW-1:0] chunk_cnt;
  logic          xfer, last_chunk;

  assign ks.ks_data  = active[255 -: OUT_WIDTH];
  assign ks.ks_valid = ks_valid_q;
  assign xfer        = ks_valid_q && ks.ks_ready;
  assign last_chunk  = (CHUNKS == 1) || (chunk_cnt == CW'(CHUNKS - 1));

  always_comb begin
    state_d     = state_q;
    is_reseed_d = is_reseed_q;
    next_d      = 1'b0;
    reseed_d    = 1'b0;
    capture     = 1'b0;
    blk_inc     = 1'b0;
    blk_clr     = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (!pf_full && drbg_init_ready && !drbg_busy) begin
          if (blk_cnt == 17'(RESEED_BLOCKS)) begin
            reseed_d    = 1'b1;
            is_reseed_d = 1'b1;
          end else begin
            next_d      = 1'b1;
            is_reseed_d = 1'b0;
          end
          state_d = F_START;
        end
      end
      F_START: begin
        if (drbg_busy) state_d = F_DONE;
      end
      F_DONE: begin
        if (!drbg_busy) begin
          if (is_reseed_q) begin
            blk_clr = 1'b1;
            state_d = F_IDLE;
          end else if (drbg_next_ready) begin
            // A flush landing on the completion cycle discards the word just like an earlier one.
            blk_inc = 1'b1;
            capture = !(drop_q || flush);
            state_d = F_IDLE;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= F_IDLE;
      is_reseed_q <= 1'b0;
      drbg_next   <= 1'b0;
      drbg_reseed <= 1'b0;
      drop_q      <= 1'b0;
      blk_cnt     <= '0;
    end else begin
      state_q     <= state_d;
      is_reseed_q <= is_reseed_d;
      drbg_next   <= next_d;
      drbg_reseed <= reseed_d;
      if (state_q == F_DONE && state_d == F_IDLE) drop_q <= 1'b0;
      else if (flush && state_q != F_IDLE)      drop_q <= 1'b1;
      if (blk_clr)      blk_cnt <= '0;
      else if (blk_inc) blk_cnt <= blk_cnt + 17'd1;
    end
  end

  // Capture only happens while pf is empty, so it never collides with the pf->active move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pf         <= '0;
      pf_full    <= 1'b0;
      active     <= '0;
      chunk_cnt  <= '0;
      ks_valid_q <= 1'b0;
    end else if (flush) begin
      ks_valid_q <= 1'b0;
      pf_full    <= 1'b0;
      chunk_cnt  <= '0;
    end else begin
      if (capture) begin
        pf      <= drbg_random_bits;
        pf_full <= 1'b1;
      end
      if (!ks_valid_q && pf_full) begin
        active     <= pf;
        pf_full    <= 1'b0;
        chunk_cnt  <= '0;
        ks_valid_q <= 1'b1;
      end else if (xfer) begin
        chunk_cnt <= chunk_cnt + 1'b1;
        if (last_chunk && pf_full) begin
          active  <= pf;
          pf_full <= 1'b0;
        end else begin
          active <= active << OUT_WIDTH;
          if (last_chunk) ks_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef KS_UNDERRUN_CNT_EN
  logic delivered_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delivered_q  <= 1'b0;
      ks_underruns <= '0;
    end else begin
      if (xfer && !flush) delivered_q <= 1'b1;
      if (delivered_q && ks.ks_ready && !ks_valid_q && ks_underruns != '1)
        ks_underruns <= ks_underruns + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_drbg_keystream_serializer.sv
// Directed + randomized bench for drbg_keystream_serializer with a DRBG model and chunk scoreboard.
module tb_drbg_keystream_serializer;

  localparam int RB = 2;
  localparam int OW = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] drbg_random_bits;
  logic         drbg_next_ready, drbg_init_ready, drbg_busy;
  logic         drbg_next, drbg_reseed, flush;
`ifdef KS_UNDERRUN_CNT_EN
  logic [15:0]  ks_underruns;
`endif

  drbg_keystream_serializer_if #(.OUT_WIDTH(OW)) ks_if ();

  drbg_keystream_serializer #(.OUT_WIDTH(OW), .RESEED_BLOCKS(RB)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .drbg_random_bits (drbg_random_bits),
    .drbg_next_ready  (drbg_next_ready),
    .drbg_init_ready  (drbg_init_ready),
    .drbg_busy        (drbg_busy),
    .drbg_next        (drbg_next),
    .drbg_reseed      (drbg_reseed),
    .flush            (flush),
    .ks               (ks_if.master)
`ifdef KS_UNDERRUN_CNT_EN
    ,
    .ks_underruns     (ks_underruns)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]   exp_q[$];
  bit           op_log[$];
  bit           op_active, op_is_gen, op_discard;
  int           op_left, gens_since, words_gen, discards, gaps, und_cnt;
  int           lat, rlat;
  bit           started, want_msb, prev_hold;
  logic [7:0]   prev_data, msb_exp;
  logic [255:0] w;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, then advance the reference model with what
  // the DUT will sample on the next rising edge.
  task step(input logic rdy, input logic fl);
    @(negedge clk);
    ks_if.ks_ready = rdy;
    flush          = fl;
    if (prev_hold) begin
      check("hold_valid", ks_if.ks_valid, 1'b1);
      check("hold_data", ks_if.ks_data, prev_data);
    end
    prev_hold = ks_if.ks_valid && !rdy && !fl;
    prev_data = ks_if.ks_data;
    if (ks_if.ks_valid && rdy && !fl) begin
      check("chunk_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) check("ks_data", ks_if.ks_data, exp_q.pop_front());
      started = 1'b1;
    end else if (started && rdy && !ks_if.ks_valid && und_cnt < 65535) begin
      und_cnt++;
    end
    if (!ks_if.ks_valid) gaps++;
    if (fl) begin
      exp_q.delete();
      if (op_active && op_is_gen) op_discard = 1'b1;
      want_msb = 1'b1;
    end
    if (drbg_next || drbg_reseed) begin
      check("req_exclusive", drbg_next & drbg_reseed, 1'b0);
      check("req_while_busy", drbg_busy, 1'b0);
      check("req_kind", drbg_reseed, (gens_since == RB) ? 1'b1 : 1'b0);
      op_log.push_back(drbg_reseed);
      op_active       = 1'b1;
      op_is_gen       = drbg_next;
      op_discard      = 1'b0;
      op_left         = drbg_next ? lat : rlat;
      drbg_busy       = 1'b1;
      drbg_next_ready = 1'b0;
      gens_since      = drbg_reseed ? 0 : gens_since + 1;
    end else if (op_active) begin
      op_left--;
      if (op_left == 0) begin
        op_active = 1'b0;
        drbg_busy = 1'b0;
        if (op_is_gen) begin
          if (words_gen == 0) begin
            for (int i = 0; i < 32; i++) w[255 - 8*i -: 8] = 8'(i + 1);
          end else begin
            w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          end
          words_gen++;
          drbg_random_bits = w;
          drbg_next_ready  = 1'b1;
          if (op_discard) begin
            discards++;
          end else begin
            for (int i = 0; i < 32; i++) exp_q.push_back(w[255 - 8*i -: 8]);
            if (want_msb) begin
              msb_exp  = w[255:248];
              want_msb = 1'b0;
            end
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0; flush = 1'b0; ks_if.ks_ready = 1'b0;
    drbg_random_bits = '0; drbg_next_ready = 1'b0; drbg_init_ready = 1'b0; drbg_busy = 1'b0;
    op_active = 0; op_is_gen = 0; op_discard = 0; op_left = 0; gens_since = 0; words_gen = 0;
    discards = 0; gaps = 0; und_cnt = 0; started = 0; want_msb = 0; prev_hold = 0;
    prev_data = '0; msb_exp = '0; w = '0;
    lat = 4; rlat = 3;

    // Reset values
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_ks_valid", ks_if.ks_valid, 1'b0);
    check("rst_ks_data", ks_if.ks_data, 8'h00);
    check("rst_next", drbg_next, 1'b0);
    check("rst_reseed", drbg_reseed, 1'b0);
`ifdef KS_UNDERRUN_CNT_EN
    check("rst_underruns", ks_underruns, 16'h0000);
`endif
    reset_n = 1'b1;

    // No request before the DRBG reports instantiation done
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check("no_req_before_init", drbg_next, 1'b0);
    end
    drbg_init_ready = 1'b1;

    // First word 0x0102..20 comes out MSB-first on consecutive cycles
    n = 0;
    do begin step(1'b1, 1'b0); n++; end while (!ks_if.ks_valid && n < 100);
    check("t1_first_valid", ks_if.ks_valid, 1'b1);
    check("t1_one_next", op_log.size(), 1);
    check("t1_chunk0", ks_if.ks_data, 8'h01);
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 1'b0);
      check("t1_valid", ks_if.ks_valid, 1'b1);
      check("t1_chunk", ks_if.ks_data, 8'(i + 1));
    end

    // Continuous drain: no bubbles across word boundaries, reseeds included
    gaps = 0;
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0);
    check("t2_no_gaps", gaps, 0);

    // Request order with RESEED_BLOCKS=2
    check("t3_op0_next", op_log[0], 1'b0);
    check("t3_op1_next", op_log[1], 1'b0);
    check("t3_op2_reseed", op_log[2], 1'b1);
    check("t3_op3_next", op_log[3], 1'b0);

    // Random backpressure
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'b0);

    // Flush while a generate is in flight
    n = 0;
    do begin step(1'b1, 1'b0); n++; end
    while (!(ks_if.ks_valid && op_active && op_is_gen) && n < 200);
    check("t5_inflight_found", op_active && op_is_gen, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("t5_valid_dropped", ks_if.ks_valid, 1'b0);
    n = 0;
    while (!ks_if.ks_valid && n < 100) begin step(1'b1, 1'b0); n++; end
    check("t5_refill_valid", ks_if.ks_valid, 1'b1);
    check("t5_first_msb", ks_if.ks_data, msb_exp);
    check("t5_discards", discards, 1);

    // Slow DRBG so the consumer starves
    lat = 20;
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
`ifdef KS_UNDERRUN_CNT_EN
    check("t6_underruns", ks_underruns, und_cnt);
`endif
    lat = 4;
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
`ifdef KS_UNDERRUN_CNT_EN
    check("t6_underruns_end", ks_underruns, und_cnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
